// File: rtl/shift_defs.sv
// ==== shift_defs: op and FSM state encodings shared by the shifter and ALU decode ====
// ==== Rev 1.0 ====
`default_nettype none

package shift_defs;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } shift_op_e;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/shift_step.sv
// ==== shift_step: one combinational shift/rotate by k (0..STEP) positions ====
// ==== Rev 1.0 ====
`default_nettype none

module shift_step
  import shift_defs::*;
#(
  parameter int N    = 32,
  parameter int STEP = 1,
  parameter int KW   = $clog2(STEP + 1)
) (
  input  logic [N-1:0]  value,
  input  shift_op_e     op,
  input  logic [KW-1:0] k,
  output logic [N-1:0]  shifted
);

  // Left amount for the rotate; 7 bits covers N - k up to 64.
  logic [6:0] lsh;

  always_comb begin
    lsh     = 7'(N) - 7'(k);
    shifted = value;
    case (op)
      OP_SLL: shifted = value << k;
      OP_SRL: shifted = value >> k;
      OP_SRA: shifted = $signed(value) >>> k;
      OP_ROR: shifted = (value >> k) | (value << lsh);
      default: shifted = value;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/iterative_shifter.sv
// ==== iterative_shifter: multi-cycle SLL/SRL/SRA/ROR, up to STEP bits per cycle ====
// ==== Rev 1.0 ====
`default_nettype none

module iterative_shifter
  import shift_defs::*;
#(
  parameter int N    = 32,
  parameter int STEP = 1,
  parameter int SW   = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [N-1:0]  D,
  input  logic [SW-1:0] shamt,
  output logic [N-1:0]  Q,
  output logic          busy,
  output logic          done
);

  localparam int KW = $clog2(STEP + 1);

  state_e        state, state_nxt;
  shift_op_e     op_reg, op_nxt;
  logic [SW-1:0] rem, rem_nxt;
  logic [N-1:0]  q_nxt, stepped;
  logic [KW-1:0] k;
  logic          done_nxt;
  logic          last_step;

  shift_step #(.N(N), .STEP(STEP), .KW(KW)) u_step (
    .value   (Q),
    .op      (op_reg),
    .k       (k),
    .shifted (stepped)
  );

  assign busy = (state == ST_SHIFT);

  // Compare in 32 bits so STEP never truncates against a narrow rem.
  assign last_step = (32'(rem) <= 32'(STEP));
  assign k         = last_step ? KW'(rem) : KW'(STEP);

  always_comb begin
    state_nxt = state;
    q_nxt     = Q;
    rem_nxt   = rem;
    op_nxt    = op_reg;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          q_nxt   = D;
          op_nxt  = shift_op_e'(op);
          rem_nxt = shamt;
          if (shamt == '0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        q_nxt   = stepped;
        rem_nxt = rem - SW'(k);
        if (last_step) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      Q      <= '0;
      rem    <= '0;
      op_reg <= OP_SLL;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      Q      <= q_nxt;
      rem    <= rem_nxt;
      op_reg <= op_nxt;
      done   <= done_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_iterative_shifter.sv
// ==== tb_iterative_shifter: directed + random checks of two shifter configurations ====
// ==== Rev 1.0 ====
`default_nettype none

module tb_iterative_shifter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start8 = 1'b0;
  logic [1:0]  op8 = 2'd0;
  logic [7:0]  d8 = '0;
  logic [2:0]  sh8 = '0;
  logic [7:0]  q8;
  logic        busy8, done8;

  logic        start32 = 1'b0;
  logic [1:0]  op32 = 2'd0;
  logic [31:0] d32 = '0;
  logic [4:0]  sh32 = '0;
  logic [31:0] q32;
  logic        busy32, done32;

  int tests = 0;
  int fails = 0;

  iterative_shifter #(.N(8), .STEP(1)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .D(d8), .shamt(sh8),
    .Q(q8), .busy(busy8), .done(done8)
  );

  iterative_shifter #(.N(32), .STEP(4)) u_dut32 (
    .clk(clk), .rst(rst), .start(start32), .op(op32), .D(d32), .shamt(sh32),
    .Q(q32), .busy(busy32), .done(done32)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] q_of(input int w);
    return w != 0 ? 64'(q32) : 64'(q8);
  endfunction
  function automatic logic [63:0] busy_of(input int w);
    return w != 0 ? 64'(busy32) : 64'(busy8);
  endfunction
  function automatic logic [63:0] done_of(input int w);
    return w != 0 ? 64'(done32) : 64'(done8);
  endfunction

  task automatic drive(input int w, input logic s, input logic [1:0] o,
                       input logic [63:0] d, input int sh);
    if (w != 0) begin
      start32 = s; op32 = o; d32 = d[31:0]; sh32 = 5'(sh);
    end else begin
      start8 = s; op8 = o; d8 = d[7:0]; sh8 = 3'(sh);
    end
  endtask

  // Reference: apply the shift one bit position at a time, sh times.
  function automatic logic [63:0] model(input int n, input logic [1:0] o,
                                        input logic [63:0] d, input int sh);
    logic [63:0] mask;
    logic [63:0] v;
    mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    v = d & mask;
    for (int i = 0; i < sh; i++) begin
      case (o)
        2'd0: v = (v << 1) & mask;
        2'd1: v = v >> 1;
        2'd2: v = (v >> 1) | (64'(v[n-1]) << (n - 1));
        default: v = (v >> 1) | (64'(v[0]) << (n - 1));
      endcase
    end
    return v;
  endfunction

  // Issues one op in the current cycle; returns positioned in the done cycle.
  task automatic run(input int w, input logic [1:0] o, input logic [63:0] d,
                     input int sh, input bit glitch);
    int n, step, lat, cyc;
    logic [63:0] exp;
    n    = (w != 0) ? 32 : 8;
    step = (w != 0) ? 4 : 1;
    lat  = 1 + (sh + step - 1) / step;
    exp  = model(n, o, d, sh);
    drive(w, 1'b1, o, d, sh);
    tick();
    cyc = 1;
    while (done_of(w) == 0 && cyc < 40) begin
      chk("busy_during_shift", busy_of(w), 64'd1);
      if (glitch && cyc == 1)
        drive(w, 1'b1, o ^ 2'd1, ~d, (sh + 1) % n);
      else
        drive(w, 1'b0, 2'($urandom), {$urandom, $urandom}, $urandom_range(0, n - 1));
      tick();
      cyc++;
    end
    drive(w, 1'b0, o, d, sh);
    chk("latency", 64'(cyc), 64'(lat));
    chk("done_pulse", done_of(w), 64'd1);
    chk("busy_at_done", busy_of(w), 64'd0);
    chk("result", q_of(w), exp);
  endtask

  task automatic idle_check(input int w, input logic [63:0] qexp);
    tick();
    chk("done_one_cycle", done_of(w), 64'd0);
    chk("q_holds", q_of(w), qexp);
  endtask

  initial begin
    int w, n, sh;
    logic [1:0] o;
    logic [63:0] d;

    tick();
    tick();
    chk("rst_q8", 64'(q8), 64'd0);
    chk("rst_busy8", 64'(busy8), 64'd0);
    chk("rst_done8", 64'(done8), 64'd0);
    chk("rst_q32", 64'(q32), 64'd0);
    rst = 1'b0;

    run(0, 2'd2, 64'h96, 3, 1'b0);
    chk("sra_0x96_by3", 64'(q8), 64'hF2);
    idle_check(0, 64'hF2);
    run(0, 2'd0, 64'h96, 3, 1'b0);
    chk("sll_0x96_by3", 64'(q8), 64'hB0);
    idle_check(0, 64'hB0);
    run(0, 2'd3, 64'h96, 3, 1'b0);
    chk("ror_0x96_by3", 64'(q8), 64'hD2);
    idle_check(0, 64'hD2);
    run(0, 2'd1, 64'h96, 0, 1'b0);
    chk("srl_by0", 64'(q8), 64'h96);
    idle_check(0, 64'h96);

    run(1, 2'd1, 64'h8000_0000, 31, 1'b0);
    chk("srl32_by31", 64'(q32), 64'h1);
    idle_check(1, 64'h1);

    // Back-to-back issue in the done cycle, second op hit by a stray start.
    run(0, 2'd0, 64'h5A, 2, 1'b0);
    run(0, 2'd1, 64'hC3, 4, 1'b1);
    chk("b2b_srl", 64'(q8), 64'h0C);
    idle_check(0, 64'h0C);

    // Abort in the second SHIFT cycle.
    drive(0, 1'b1, 2'd0, 64'hFF, 5);
    tick();
    drive(0, 1'b0, 2'd0, 64'hFF, 5);
    tick();
    rst = 1'b1;
    tick();
    chk("abort_q", 64'(q8), 64'd0);
    chk("abort_busy", 64'(busy8), 64'd0);
    chk("abort_done", 64'(done8), 64'd0);
    rst = 1'b0;
    tick();
    chk("abort_no_done", 64'(done8), 64'd0);
    run(0, 2'd3, 64'h81, 5, 1'b0);
    idle_check(0, 64'h0C);

    for (int i = 0; i < 40; i++) begin
      w  = int'($urandom_range(0, 1));
      n  = (w != 0) ? 32 : 8;
      o  = 2'($urandom);
      d  = {$urandom, $urandom};
      sh = int'($urandom_range(0, n - 1));
      run(w, o, d, sh, bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle_check(w, model(n, o, d, sh));
    end
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
